matmul_host_ctrl: RTL
=====================

# matmul_host_ctrl

Initiator side of the matrix-multiplier start/done handshake.
- Collects A and B as a Q7.9 element stream and presents them as 16x16 arrays.
- Raises start, waits for done, captures C, then streams C back out.
- Sits between the system-side streaming interface and the matrix-multiplier top, which counts cycles while start is held and pulses done.

## Interface
Parameters:
- para_int_bits, 7, integer bits of each signed fixed-point element
- para_frac_bits, 9, fractional bits; word width W = para_int_bits + para_frac_bits (16)
- DIM, 16, matrix dimension
- TIMEOUT, 64, maximum cycles in RUN without done before abort

Ports (clock and reset first):
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  load-stream element valid
- in_ready  out  1  load-stream element accepted when in_valid & in_ready
- in_data  in  W signed  element; order is A row-major (256 beats), then B row-major (256 beats)
- mm_start  out  1  held high while waiting for the multiplier
- mm_done  in  1  multiplier completion pulse
- mm_A  out  W signed [0:DIM-1][0:DIM-1]  A operand array
- mm_B  out  W signed [0:DIM-1][0:DIM-1]  B operand array
- mm_C  in  W signed [0:DIM-1][0:DIM-1]  product array, valid when mm_done is high
- out_valid  out  1  result element valid
- out_ready  in  1  result element consumed when out_valid & out_ready
- out_data  out  W signed  C element, row-major
- out_last  out  1  high on C[DIM-1][DIM-1]
- busy  out  1  high in RUN or DRAIN
- err  out  1  sticky timeout flag

## Operation
FSM states are LOAD, RUN and DRAIN. Reset enters LOAD.
- LOAD:
  - in_ready=1.
  - Each accepted beat k (0..511) writes mm_A[k/16][k%16] when k<256, otherwise mm_B[(k-256)/16][(k-256)%16].
  - The accepted beat with k=511 moves the FSM to RUN and clears the index.
- RUN:
  - mm_start=1 and in_ready=0.
  - A run counter increments each cycle.
  - If mm_done is sampled high, all of mm_C is captured into the C buffer and the FSM moves to DRAIN.
  - Otherwise, when the run counter reaches TIMEOUT-1, err is set and the FSM returns to LOAD. The C buffer is unchanged and no output is produced.
- DRAIN:
  - out_valid=1 and out_data = Cbuf[idx/16][idx%16].
  - out_last=1 when idx=255.
  - idx advances only on a handshake.
  - The handshake with idx=255 moves the FSM to LOAD with idx=0.
- mm_done outside RUN is ignored.
- mm_A and mm_B hold their values outside LOAD. In LOAD they are overwritten only by accepted beats.
- No arithmetic is performed. Elements pass through bit-exact: no rounding, saturation or sign change.
- Index counters wrap only through the state transitions above and never exceed 511 or 255.
- err is cleared only by rst.

## Timing
- Reset values (asynchronous):
  - state=LOAD, indices=0, run counter=0.
  - mm_A, mm_B and Cbuf all zero.
  - mm_start=0, out_valid=0, out_last=0, busy=0, err=0.
  - in_ready=1 once rst is low.
- All outputs decode from registered state and indices. There is no combinational path from in_valid, out_ready or mm_done to any output.
- mm_start rises the cycle after the 512th accepted beat.
- The responder needs about 32 cycles of start before done. TIMEOUT=64 gives margin.
- out_valid rises the cycle after mm_done is sampled. With out_ready tied high, the 256 beats follow back-to-back.
- in_ready rises the cycle after the final out handshake.
- Back-pressure on either stream stalls only that stream. Data and indices are stable while valid && !ready.
- Reset asserted mid-LOAD, mid-RUN or mid-DRAIN aborts immediately. A partial load is discarded and a new load starts from beat 0.

## Structure
- Shared package matmul_pkg holds:
  - DIM, WORD_W
  - LOAD_BEATS=2*DIM*DIM, DRAIN_BEATS=DIM*DIM
  - the state enum {LOAD, RUN, DRAIN}
  - the signed element typedef
- One sub-module, mat_index_ctr: a row/column counter with enable, clear and terminal-count outputs.
  - Instanced once for load (512) and once for drain (256).

## Test plan
- Load A=identity (1.0=16'h0200) and B[i][j]=i*16+j in Q7.9 with no stalls. A model responder pulses done after 32 start cycles and returns C=B. Required: mm_start rises at cycle 513; out_data sequence equals B row-major; out_last only on beat 255; in_ready returns the cycle after.
- Random in_valid gaps (~30%) and out_ready stalls (~50%). Required: no dropped or duplicated elements; out_data held stable during stalls; exact element order preserved.
- Responder never asserts done. Required: err=1 exactly TIMEOUT cycles after mm_start rises; mm_start drops with it; FSM returns to LOAD; no out_valid.
- Negative values, e.g. 16'h8000 and 16'hFE00 (-1.0), in A and B, with the responder echoing them into C. Required: bit-exact passthrough on mm_A/mm_B and on out_data.
- Assert rst at beat 300 of LOAD, and separately mid-DRAIN at beat 100. Required: all outputs return to reset values immediately; the next full load and run yields a complete, correct 256-beat drain.
- mm_done pulsed during LOAD. Required: ignored; FSM stays in LOAD; Cbuf unchanged.

Source files
------------

// File: rtl/matmul_pkg.sv
// matmul_pkg: shared constants, state encoding and element type for the matmul host controller
package matmul_pkg;

    localparam int DIM         = 16;
    localparam int WORD_W      = 16;
    localparam int LOAD_BEATS  = 2 * DIM * DIM;
    localparam int DRAIN_BEATS = DIM * DIM;

    typedef enum logic [1:0] {LOAD, RUN, DRAIN} state_t;

    typedef logic signed [WORD_W-1:0] elem_t;

endpackage

// File: rtl/mat_index_ctr.sv
// mat_index_ctr: row/column beat counter with enable, clear and terminal-count flag
module mat_index_ctr
    import matmul_pkg::*;
#(
    parameter int COLS = DIM,
    parameter int ROWS = DIM,
    localparam int CW  = $clog2(COLS),
    localparam int RW  = $clog2(ROWS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          tc
);

    logic col_end;

    assign col_end = (col == CW'(COLS - 1));
    assign tc      = col_end && (row == RW'(ROWS - 1));

    // Column steps on every enable; row steps on column wrap; both return to zero after terminal count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row <= '0;
            col <= '0;
        end else if (clr) begin
            row <= '0;
            col <= '0;
        end else if (en) begin
            col <= col_end ? '0 : col + 1'b1;
            if (col_end)
                row <= tc ? '0 : row + 1'b1;
        end
    end

endmodule

// File: rtl/matmul_host_ctrl.sv
// matmul_host_ctrl: streams A/B into operand arrays, runs the multiplier handshake, streams C back out
module matmul_host_ctrl #(
    parameter int para_int_bits  = 7,
    parameter int para_frac_bits = 9,
    parameter int DIM            = 16,
    parameter int TIMEOUT        = 64,
    localparam int W             = para_int_bits + para_frac_bits
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in_data,
    output logic                mm_start,
    input  logic                mm_done,
    output logic signed [W-1:0] mm_A [0:DIM-1][0:DIM-1],
    output logic signed [W-1:0] mm_B [0:DIM-1][0:DIM-1],
    input  logic signed [W-1:0] mm_C [0:DIM-1][0:DIM-1],
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] out_data,
    output logic                out_last,
    output logic                busy,
    output logic                err
);

    import matmul_pkg::*;

    localparam int DW = $clog2(DIM);
    localparam int TW = $clog2(TIMEOUT);

    state_t              state;
    logic [TW-1:0]       run_cnt;
    logic signed [W-1:0] c_buf [0:DIM-1][0:DIM-1];

    logic [DW:0]         ld_row;
    logic [DW-1:0]       ld_col;
    logic                ld_tc;
    logic                ld_fire;
    logic [DW-1:0]       dr_row;
    logic [DW-1:0]       dr_col;
    logic                dr_tc;
    logic                dr_fire;

    assign ld_fire  = in_valid && in_ready;
    assign dr_fire  = out_valid && out_ready;
    assign out_data = c_buf[dr_row][dr_col];
    assign out_last = out_valid && dr_tc;

    // Load index walks 2*DIM rows: the upper half of the row range addresses B
    mat_index_ctr #(.COLS(DIM), .ROWS(2 * DIM)) u_ld_ctr (
        .clk (clk),
        .rst (rst),
        .en  (ld_fire),
        .clr (state != LOAD),
        .row (ld_row),
        .col (ld_col),
        .tc  (ld_tc)
    );

    mat_index_ctr #(.COLS(DIM), .ROWS(DIM)) u_dr_ctr (
        .clk (clk),
        .rst (rst),
        .en  (dr_fire),
        .clr (state != DRAIN),
        .row (dr_row),
        .col (dr_col),
        .tc  (dr_tc)
    );

    // Control FSM: sequences load, multiplier run (with timeout) and drain, all handshake outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LOAD;
            run_cnt   <= '0;
            in_ready  <= 1'b1;
            mm_start  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (ld_fire && ld_tc) begin
                        state    <= RUN;
                        run_cnt  <= '0;
                        in_ready <= 1'b0;
                        mm_start <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    if (mm_done) begin
                        state     <= DRAIN;
                        mm_start  <= 1'b0;
                        out_valid <= 1'b1;
                    end else if (run_cnt == TW'(TIMEOUT - 1)) begin
                        state    <= LOAD;
                        mm_start <= 1'b0;
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                        err      <= 1'b1;
                    end else begin
                        run_cnt <= run_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (dr_fire && dr_tc) begin
                        state     <= LOAD;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    // Operand arrays: written only by accepted load beats, held otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mm_A <= '{default: '{default: '0}};
            mm_B <= '{default: '{default: '0}};
        end else if (ld_fire) begin
            if (ld_row[DW])
                mm_B[ld_row[DW-1:0]][ld_col] <= in_data;
            else
                mm_A[ld_row[DW-1:0]][ld_col] <= in_data;
        end
    end

    // Result buffer: snapshot of the whole product on the done pulse while running
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            c_buf <= '{default: '{default: '0}};
        else if (state == RUN && mm_done)
            c_buf <= mm_C;
    end

endmodule
